// File: rtl/mc_avg.sv
// mc_avg: discounted Monte-Carlo payoff averager.
// Requests 2^LOG_N payoffs one at a time, averages them and scales by disc.
//
// Ports:
//   clk      : single clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : one-cycle pulse launching a run (accepted only in IDLE)
//   disc     : unsigned Q0.12 discount factor, latched at accepted start
//   in_valid : payoff valid from the MC core (honoured only in WAIT)
//   in_price : unsigned 12-bit payoff
//   mc_start : one-cycle request for the next path
//   busy     : high from the cycle after an accepted start through DONE
//   done     : one-cycle pulse on completion or abort
//   err      : last run aborted on timeout; held until next accepted start
//   avg      : discounted mean payoff, held between runs
module mc_avg #(
    parameter int LOG_N   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] disc,
    input  logic        in_valid,
    input  logic [11:0] in_price,
    output logic        mc_start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] avg
);

    localparam int N  = 1 << LOG_N;
    // 12+LOG_N bits holds N full-scale payoffs, so the sum cannot wrap.
    localparam int AW = 12 + LOG_N;
    localparam int CW = LOG_N + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wd;
    logic [11:0]   disc_q;
    logic [11:0]   avg_q;
    logic          err_q;

    logic [CW-1:0] cnt_nxt;
    logic [WW-1:0] wd_nxt;
    logic          last_sample;
    logic          wd_expire;
    logic [11:0]   mean;
    logic [23:0]   prod;

    assign cnt_nxt     = cnt + CW'(1);
    assign wd_nxt      = wd + WW'(1);
    assign last_sample = (cnt_nxt == CW'(N));
    assign wd_expire   = (wd_nxt == WW'(TIMEOUT));

    // Truncating divide by N, then Q0.12 scale keeping the integer part.
    assign mean = acc[AW-1:LOG_N];
    assign prod = {12'd0, mean} * {12'd0, disc_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            cnt    <= '0;
            wd     <= '0;
            disc_q <= '0;
            avg_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_ISSUE;
                        acc    <= '0;
                        cnt    <= '0;
                        wd     <= '0;
                        err_q  <= 1'b0;
                        disc_q <= disc;
                    end
                end
                S_ISSUE: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (in_valid) begin
                        acc <= acc + AW'(in_price);
                        cnt <= cnt_nxt;
                        if (last_sample) begin
                            state <= S_CALC;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else begin
                        wd <= wd_nxt;
                        if (wd_expire) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    avg_q <= prod[23:12];
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mc_start = (state == S_ISSUE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign err      = err_q;
    assign avg      = avg_q;

endmodule

// File: doc/mc_avg.md
MC_AVG -- requirements
Module: mc_avg

Interface
REQ-001 Parameter LOG_N, default 8, log2 of payoff samples averaged per run (N = 2^LOG_N).
REQ-002 Parameter TIMEOUT, default 1023, maximum cycles spent waiting for one payoff before abort.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse launching a run of N payoffs.
REQ-006 disc  input  12  discount factor, unsigned Q0.12; sampled at the accepted start.
REQ-007 in_valid  input  1  upstream MC core payoff valid.
REQ-008 in_price  input  12  upstream payoff, unsigned integer.
REQ-009 mc_start  output  1  one-cycle pulse requesting the next path from the MC core.
REQ-010 busy  output  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
REQ-011 done  output  1  one-cycle pulse on run completion or abort.
REQ-012 err  output  1  high when the last run aborted on timeout; held until next accepted start.
REQ-013 avg  output  12  discounted mean payoff; held between runs.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, CALC, DONE.
REQ-015 IDLE: start=1 -> ISSUE; clear accumulator, sample counter, watchdog, err; latch disc.
REQ-016 ISSUE: mc_start=1 for exactly this cycle; next state WAIT; clear watchdog.
REQ-017 WAIT: in_valid=1 -> accumulator += in_price, sample counter +1; if counter reaches N -> CALC, else -> ISSUE.
REQ-018 WAIT: in_valid=0 -> watchdog +1; watchdog reaching TIMEOUT -> DONE with err set, avg unchanged.
REQ-019 in_valid outside WAIT is ignored; no accumulation.
REQ-020 start while busy is ignored; no restart, no state change.
REQ-021 Accumulator width 12+LOG_N bits; overflow impossible by construction.
REQ-022 CALC: mean = accumulator >> LOG_N (truncate); avg <= (mean * latched disc) >> 12 (truncate, 24-bit product); next state DONE.
REQ-023 DONE: done=1 for this cycle only; next state IDLE.
REQ-024 Latency: Nth payoff accepted at edge t -> CALC during cycle t+1, done=1 and new avg visible in cycle t+2.
REQ-025 Each path costs at least 2 cycles (ISSUE + WAIT); back-to-back in_valid in consecutive WAIT cycles is not possible by construction.
REQ-026 start sampled in the DONE cycle is ignored; accepted only in IDLE.

Reset
REQ-027 rst=1 at a rising edge -> state IDLE; mc_start, busy, done, err = 0; avg = 0; accumulator, counters, latched disc = 0.
REQ-028 rst takes priority over every other input, including mid-run; the run in progress is discarded with no done pulse.

Verification (LOG_N=2, TIMEOUT=15 unless stated)
REQ-029 start, disc=12'hFFF, payoffs 100,200,300,400, one per mc_start -> exactly 4 mc_start pulses, done once, avg=249, err=0.
REQ-030 Same payoffs, disc=12'h800 -> avg=125; done exactly 2 cycles after the edge accepting payoff 400.
REQ-031 Four payoffs of 12'hFFF, disc=12'hFFF -> avg=4094, no overflow.
REQ-032 start, two payoffs, then in_valid held low -> done and err=1 after 15 WAIT cycles, avg keeps prior value, busy drops after DONE.
REQ-033 rst pulsed after second payoff -> all outputs 0 next cycle, no done; fresh run afterwards yields the correct avg.
REQ-034 start pulsed during WAIT and stray in_valid during ISSUE/IDLE -> ignored; mc_start count and avg unchanged versus clean run.
